// File: rtl/led_chase_pkg.sv
// Shared types and constants for the LED running-light checker.
package led_chase_pkg;

    localparam int LED_N = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return IDX_W'((int'(i) + 1) % LED_N);
    endfunction

endpackage

// File: rtl/led_chase_checker_decoder.sv
// Combinational decode of an active-low one-hot LED pattern to its bit position.
module onehot_low_decoder
    import led_chase_pkg::*;
(
    input  logic [LED_N-1:0] i_pat,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [LED_N-1:0] w_low;

    assign w_low   = ~i_pat;
    assign o_valid = (w_low != '0) && ((w_low & (w_low - LED_N'(1))) == '0);

    // OR of lit positions; exact only when a single LED is lit, which o_valid qualifies
    always_comb begin
        o_idx = '0;
        for (int n = 0; n < LED_N; n++) begin
            o_idx = o_idx | (w_low[n] ? IDX_W'(n) : '0);
        end
    end

endmodule

// File: rtl/led_chase_checker.sv
// Monitors the running-light LED bus: tracks single-position steps, locks on a
// healthy sequence and counts skip/reverse/invalid/stall faults while locked.
module led_chase_checker
    import led_chase_pkg::*;
#(
    parameter int LOCK_STEPS = 2,
    parameter int STALL_CYC  = 64,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LED_N-1:0] led_in,
    input  logic             clr_err,
    output logic [IDX_W-1:0] idx,
    output logic             idx_valid,
    output logic             step_pulse,
    output logic             err_pulse,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int SC_W = (STALL_CYC > 0) ? $clog2(STALL_CYC + 1) : 1;
    localparam int GD_W = (LOCK_STEPS > 0) ? $clog2(LOCK_STEPS + 1) : 1;

    localparam logic [1:0] ST_SEARCH = 2'(SEARCH);
    localparam logic [1:0] ST_TRACK  = 2'(TRACK);
    localparam logic [1:0] ST_LOCKED = 2'(LOCKED);

    localparam logic [SC_W-1:0] STALL_LAST = SC_W'((STALL_CYC > 0) ? STALL_CYC - 1 : 0);
    localparam logic [GD_W-1:0] GOOD_LOCK  = GD_W'(LOCK_STEPS);

    logic [LED_N-1:0] r_s;
    logic [LED_N-1:0] r_prev;
    logic [1:0]       r_state;
    logic [GD_W-1:0]  r_good;
    logic [SC_W-1:0]  r_stall;
    logic [IDX_W-1:0] r_idx;
    logic             r_idx_valid;
    logic             r_step;
    logic             r_err;
    logic             r_locked;
    logic [ERR_W-1:0] r_err_cnt;

    logic [IDX_W-1:0] w_s_idx;
    logic             w_s_valid;
    logic [IDX_W-1:0] w_p_idx;
    logic             w_p_valid;
    logic             w_chg;
    logic             w_good_step;
    logic [GD_W-1:0]  w_good_inc;
    logic [1:0]       w_state_nxt;
    logic [GD_W-1:0]  w_good_nxt;
    logic [SC_W-1:0]  w_stall_nxt;
    logic             w_step_nxt;
    logic             w_fault;

    onehot_low_decoder u_dec_s (
        .i_pat   (r_s),
        .o_idx   (w_s_idx),
        .o_valid (w_s_valid)
    );

    onehot_low_decoder u_dec_prev (
        .i_pat   (r_prev),
        .o_idx   (w_p_idx),
        .o_valid (w_p_valid)
    );

    assign w_chg       = (r_s != r_prev);
    assign w_good_step = w_chg && w_s_valid && w_p_valid && (w_s_idx == next_idx(w_p_idx));
    assign w_good_inc  = r_good + GD_W'(1);

    // Sequence FSM: next state, good-step run length, stall timer and pulse requests
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_stall_nxt = '0;
        w_step_nxt  = 1'b0;
        w_fault     = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_chg && w_s_valid) begin
                    w_state_nxt = ST_TRACK;
                    w_good_nxt  = '0;
                end else begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_TRACK: begin
                if (w_good_step) begin
                    w_good_nxt = w_good_inc;
                    if (w_good_inc == GOOD_LOCK) begin
                        w_state_nxt = ST_LOCKED;
                        w_step_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_TRACK;
                    end
                end else if (w_chg) begin
                    w_good_nxt = '0;
                    if (w_s_valid) begin
                        w_state_nxt = ST_TRACK;
                    end else begin
                        w_state_nxt = ST_SEARCH;
                    end
                end else begin
                    w_state_nxt = ST_TRACK;
                end
            end
            ST_LOCKED: begin
                if (w_good_step) begin
                    w_step_nxt = 1'b1;
                end else if (w_chg) begin
                    w_fault     = 1'b1;
                    w_state_nxt = ST_SEARCH;
                end else if ((STALL_CYC > 0) && (r_stall == STALL_LAST)) begin
                    w_fault     = 1'b1;
                    w_state_nxt = ST_SEARCH;
                end else begin
                    w_stall_nxt = (STALL_CYC > 0) ? r_stall + SC_W'(1) : '0;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
                w_good_nxt  = '0;
            end
        endcase
    end

    // Sample pipeline, FSM state and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s         <= '1;
            r_prev      <= '1;
            r_state     <= ST_SEARCH;
            r_good      <= '0;
            r_stall     <= '0;
            r_idx       <= '0;
            r_idx_valid <= 1'b0;
            r_step      <= 1'b0;
            r_err       <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_s         <= led_in;
            r_prev      <= r_s;
            r_state     <= w_state_nxt;
            r_good      <= w_good_nxt;
            r_stall     <= w_stall_nxt;
            r_idx       <= w_s_valid ? w_s_idx : r_idx;
            r_idx_valid <= w_s_valid;
            r_step      <= w_step_nxt;
            r_err       <= w_fault;
            r_locked    <= (w_state_nxt == ST_LOCKED);
        end
    end

    // Saturating fault counter; a clear coincident with a fault leaves exactly one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (clr_err) begin
            r_err_cnt <= w_fault ? ERR_W'(1) : '0;
        end else if (w_fault && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

    assign idx        = r_idx;
    assign idx_valid  = r_idx_valid;
    assign step_pulse = r_step;
    assign err_pulse  = r_err;
    assign locked     = r_locked;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_led_chase_checker.sv
// Randomized and directed bench for led_chase_checker against a behavioural model.
module tb_led_chase_checker;

    localparam int STALL = 64;
    localparam int LOCKN = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] led_in = 8'hFF;
    logic       clr_err = 1'b0;
    logic [2:0] idx;
    logic       idx_valid;
    logic       step_pulse;
    logic       err_pulse;
    logic       locked;
    logic [7:0] err_cnt;

    int checks = 0;
    int failures = 0;

    // model of the checker: sample history plus run/quiet bookkeeping
    logic [7:0] m_s, m_prev;
    int m_run;
    bit m_locked;
    int m_quiet;
    int m_idx;
    bit m_valid, m_step, m_err;
    int m_cnt;
    int cur;

    always #5 clk = ~clk;

    led_chase_checker #(.LOCK_STEPS(LOCKN), .STALL_CYC(STALL), .ERR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .led_in     (led_in),
        .clr_err    (clr_err),
        .idx        (idx),
        .idx_valid  (idx_valid),
        .step_pulse (step_pulse),
        .err_pulse  (err_pulse),
        .locked     (locked),
        .err_cnt    (err_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] pat_of(input int p);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << (p % 8));
    endfunction

    function automatic int pos_of(input logic [7:0] p);
        for (int b = 0; b < 8; b++) begin
            if (p[b] == 1'b0) return b;
        end
        return 0;
    endfunction

    function automatic bit is_valid(input logic [7:0] p);
        return $countones(~p) == 1;
    endfunction

    task automatic model_reset();
        m_s = 8'hFF; m_prev = 8'hFF;
        m_run = -1; m_locked = 0; m_quiet = 0;
        m_idx = 0; m_valid = 0; m_step = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic [7:0] led, input bit clr);
        bit chg, sv, pv, good;
        chg  = (m_s != m_prev);
        sv   = is_valid(m_s);
        pv   = is_valid(m_prev);
        good = chg && sv && pv && (pos_of(m_s) == (pos_of(m_prev) + 1) % 8);
        m_step = 0;
        m_err  = 0;
        if (m_locked) begin
            if (good) begin
                m_step = 1; m_quiet = 0;
            end else if (chg) begin
                m_err = 1; m_locked = 0; m_run = -1;
            end else begin
                m_quiet++;
                if (m_quiet == STALL) begin
                    m_err = 1; m_locked = 0; m_run = -1;
                end
            end
        end else if (m_run < 0) begin
            if (chg && sv) m_run = 0;
        end else if (good) begin
            m_run++;
            if (m_run == LOCKN) begin
                m_locked = 1; m_step = 1; m_quiet = 0;
            end
        end else if (chg) begin
            m_run = sv ? 0 : -1;
        end
        if (clr) m_cnt = m_err ? 1 : 0;
        else if (m_err && m_cnt < 255) m_cnt++;
        if (sv) m_idx = pos_of(m_s);
        m_valid = sv;
        m_prev = m_s;
        m_s = led;
    endtask

    task automatic compare_all();
        check_eq("idx", 32'(idx), 32'(m_idx));
        check_eq("idx_valid", 32'(idx_valid), 32'(m_valid));
        check_eq("step_pulse", 32'(step_pulse), 32'(m_step));
        check_eq("err_pulse", 32'(err_pulse), 32'(m_err));
        check_eq("locked", 32'(locked), 32'(m_locked));
        check_eq("err_cnt", 32'(err_cnt), 32'(m_cnt));
    endtask

    task automatic cycle(input logic [7:0] led, input bit clr);
        led_in  = led;
        clr_err = clr;
        @(posedge clk);
        model_step(led, clr);
        #1;
        compare_all();
    endtask

    task automatic hold(input logic [7:0] led, input int n);
        for (int i = 0; i < n; i++) cycle(led, 1'b0);
    endtask

    // From SEARCH: enter TRACK, two good steps to lock, then a skip fault
    task automatic relock_and_fault(input bit clr_on_fault);
        cur = (cur + 1) % 8; cycle(pat_of(cur), 1'b0);
        cur = (cur + 1) % 8; cycle(pat_of(cur), 1'b0);
        cur = (cur + 1) % 8; cycle(pat_of(cur), 1'b0);
        cur = (cur + 2) % 8; cycle(pat_of(cur), 1'b0);
        cycle(pat_of(cur), clr_on_fault);
    endtask

    initial begin
        int i_step, i_err, kind, len;
        logic [7:0] pat;
        model_reset();
        cur = 0;

        // reset state
        #12;
        compare_all();
        #5 rst_n = 1'b1;

        // 1: clean full rotation with wrap
        hold(8'hFF, 2);
        for (int p = 0; p <= 8; p++) hold(pat_of(p), 6);
        check_eq("rot_locked", 32'(locked), 32'd1);
        check_eq("rot_errcnt", 32'(err_cnt), 32'd0);
        check_eq("rot_idx", 32'(idx), 32'd0);

        // 2: skip FB -> EF while locked
        hold(8'hFD, 6);
        hold(8'hFB, 6);
        cycle(8'hEF, 1'b0);
        check_eq("skip_locked_lat1", 32'(locked), 32'd1);
        cycle(8'hEF, 1'b0);
        check_eq("skip_locked_lat2", 32'(locked), 32'd0);
        check_eq("skip_errcnt", 32'(err_cnt), 32'd1);
        hold(8'hEF, 4);
        hold(8'hDF, 6);
        hold(8'hBF, 6);
        hold(8'h7F, 6);
        check_eq("relock", 32'(locked), 32'd1);

        // 3: two LEDs lit while locked
        hold(8'hFC, 3);
        check_eq("multi_valid", 32'(idx_valid), 32'd0);
        check_eq("multi_idx_hold", 32'(idx), 32'd7);
        check_eq("multi_errcnt", 32'(err_cnt), 32'd2);

        // 4: stall on F7 while locked
        hold(8'hFE, 6);
        hold(8'hFD, 6);
        hold(8'hFB, 6);
        i_step = -1000;
        i_err  = -1;
        for (int i = 0; i < 80; i++) begin
            cycle(8'hF7, 1'b0);
            if (step_pulse && i_step < 0) i_step = i;
            if (err_pulse && i_err < 0) i_err = i;
        end
        check_eq("stall_delay", 32'(i_err - i_step), 32'd64);
        check_eq("stall_locked", 32'(locked), 32'd0);
        cur = 3;

        // 5: saturate err_cnt, then clear coincident with a fault
        for (int k = 0; k < 256; k++) relock_and_fault(1'b0);
        check_eq("sat_255", 32'(err_cnt), 32'd255);
        relock_and_fault(1'b0);
        check_eq("sat_hold", 32'(err_cnt), 32'd255);
        relock_and_fault(1'b1);
        check_eq("clr_with_fault", 32'(err_cnt), 32'd1);
        cycle(pat_of(cur), 1'b1);
        check_eq("clr_alone", 32'(err_cnt), 32'd0);

        // randomized traffic
        for (int seg = 0; seg < 400; seg++) begin
            kind = $urandom_range(0, 99);
            len  = $urandom_range(1, 6);
            if (kind < 70) begin
                cur = (cur + 1) % 8; pat = pat_of(cur);
            end else if (kind < 80) begin
                cur = (cur + $urandom_range(2, 7)) % 8; pat = pat_of(cur);
            end else if (kind < 88) begin
                pat = 8'($urandom_range(0, 255));
            end else if (kind < 95) begin
                pat = pat_of(cur);
                len = $urandom_range(60, 70);
            end else begin
                cur = $urandom_range(0, 7); pat = pat_of(cur);
            end
            for (int i = 0; i < len; i++) cycle(pat, $urandom_range(0, 31) == 0);
        end

        // 6: asynchronous reset in the middle of a locked run
        for (int p = 1; p <= 4; p++) hold(pat_of(cur + p), 3);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        cycle(8'hFB, 1'b0);
        cycle(8'hFB, 1'b0);
        check_eq("post_rst_err", 32'(err_pulse), 32'd0);
        check_eq("post_rst_locked", 32'(locked), 32'd0);
        hold(8'hF7, 3);
        hold(8'hEF, 3);
        check_eq("post_rst_lock", 32'(locked), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
